// File: rtl/mmix_mem_arbiter.sv
// rtl/mmix_mem_arbiter.sv - N-channel arbiter onto the single shared MMIX memory port
// Latches the winning request, holds it on mem_* until mem_done or watchdog expiry, then pulses done.
module mmix_mem_arbiter #(
   parameter int N_CH    = 2,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 0,
   localparam int GW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH*ADDR_W-1:0]   req_address,
   input  logic [N_CH*2-1:0]        req_datasize,
   input  logic [N_CH-1:0]          req_read,
   input  logic [N_CH-1:0]          req_write,
   input  logic [N_CH*DATA_W-1:0]   req_writedata,
   output logic [DATA_W-1:0]        req_readdata,
   output logic [N_CH-1:0]          req_done,
   output logic [N_CH-1:0]          req_err,
   output logic [GW-1:0]            grant,
   output logic                     busy,
   output logic [ADDR_W-1:0]        mem_address,
   output logic [1:0]               mem_datasize,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [DATA_W-1:0]        mem_writedata,
   input  logic [DATA_W-1:0]        mem_readdata,
   input  logic                     mem_done
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_size;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_write;
   logic [GW-1:0]       r_grant;
   logic [GW-1:0]       r_last;
   logic [31:0]         r_wdog;
   logic                r_err;
   logic [DATA_W-1:0]   r_rdata;

   logic [N_CH-1:0]     w_req;
   logic                w_found;
   logic [GW-1:0]       w_win;
   logic [GW-1:0]       w_cand;
   int                  w_idx;
   logic                w_expire;

   assign w_req    = req_read | req_write;
   assign w_expire = (TIMEOUT != 0) && (r_wdog == 32'(TIMEOUT));

   // Round robin scans from last+1; fixed priority scans from channel 0.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      w_cand  = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_idx  = (MODE == 1) ? ((int'(r_last) + 1 + k) % N_CH) : k;
         w_cand = GW'(w_idx);
         if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_next = S_BUSY;
         S_BUSY:  if (mem_done || w_expire) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_size  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         r_grant <= '0;
         r_last  <= GW'(N_CH - 1);
         r_wdog  <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_addr  <= req_address[int'(w_win)*ADDR_W +: ADDR_W];
                  r_size  <= req_datasize[int'(w_win)*2 +: 2];
                  r_wdata <= req_writedata[int'(w_win)*DATA_W +: DATA_W];
                  r_write <= req_write[w_win];
                  r_grant <= w_win;
                  r_last  <= w_win;
                  r_wdog  <= '0;
                  r_err   <= 1'b0;
               end
            end
            S_BUSY: begin
               if (TIMEOUT != 0) r_wdog <= r_wdog + 32'd1;
               // mem_done takes precedence over a coincident expiry
               if (mem_done) begin
                  if (!r_write) r_rdata <= mem_readdata;
               end else if (w_expire) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_address   = r_addr;
      mem_datasize  = r_size;
      mem_writedata = r_wdata;
      mem_read      = (r_state == S_BUSY) && !r_write;
      mem_write     = (r_state == S_BUSY) && r_write;
      req_readdata  = r_rdata;
      grant         = r_grant;
      busy          = (r_state != S_IDLE);
      req_done      = '0;
      req_err       = '0;
      if (r_state == S_DONE) begin
         req_done[r_grant] = 1'b1;
         req_err[r_grant]  = r_err;
      end
   end

endmodule

// File: tb/tb_mmix_mem_arbiter.sv
// tb/tb_mmix_mem_arbiter.sv - scoreboard bench for mmix_mem_arbiter (fixed priority + round robin)
module tb_mmix_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   typedef struct { logic [63:0] addr; logic [1:0] size; logic wr; logic [63:0] wdata; int g; int cy; } mexp_t;
   typedef struct { int ch; logic [63:0] data; logic err; int cy; } rexp_t;

   // ---------------- instance A: N_CH=2, fixed priority, TIMEOUT=8
   logic          rst_a = 1'b1;
   logic [127:0]  a_addr = '0;
   logic [3:0]    a_size = '0;
   logic [1:0]    a_rd = '0;
   logic [1:0]    a_wr = '0;
   logic [127:0]  a_wdata = '0;
   logic [63:0]   a_rdata;
   logic [1:0]    a_done, a_err;
   logic [0:0]    a_grant;
   logic          a_busy;
   logic [63:0]   a_maddr, a_mwdata, a_mrdata;
   logic [1:0]    a_msize;
   logic          a_mrd, a_mwr;
   logic          a_mdone = 1'b0;
   int            a_lat = 0;
   logic          a_fix_en = 1'b0;
   logic [63:0]   a_fix = '0;
   int            a_cnt = 0;
   logic          a_prev = 1'b0;
   mexp_t         a_mq[$];
   rexp_t         a_rq[$];

   assign a_mrdata = a_fix_en ? a_fix : ~a_maddr;

   mmix_mem_arbiter #(.N_CH(2), .ADDR_W(64), .DATA_W(64), .MODE(0), .TIMEOUT(8)) u_a (
      .clk(clk), .reset(rst_a),
      .req_address(a_addr), .req_datasize(a_size), .req_read(a_rd), .req_write(a_wr),
      .req_writedata(a_wdata), .req_readdata(a_rdata), .req_done(a_done), .req_err(a_err),
      .grant(a_grant), .busy(a_busy),
      .mem_address(a_maddr), .mem_datasize(a_msize), .mem_read(a_mrd), .mem_write(a_mwr),
      .mem_writedata(a_mwdata), .mem_readdata(a_mrdata), .mem_done(a_mdone)
   );

   // memory with a_lat cycles of latency after the first access cycle
   always @(negedge clk) begin
      if (a_mrd | a_mwr) begin
         a_mdone = (a_cnt == a_lat);
         a_cnt++;
      end else begin
         a_mdone = 1'b0;
         a_cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst_a && (a_mrd | a_mwr) && !a_prev) begin
         if (a_mq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL a_mem_unexpected: access to 0x%0h with nothing expected", a_maddr);
         end else begin
            mexp_t e;
            e = a_mq.pop_front();
            check("a_mem_addr", a_maddr, e.addr);
            check("a_mem_size", 64'(a_msize), 64'(e.size));
            check("a_mem_write", 64'(a_mwr), 64'(e.wr));
            check("a_mem_read", 64'(a_mrd), 64'(!e.wr));
            if (e.wr) check("a_mem_wdata", a_mwdata, e.wdata);
            check("a_grant", 64'(a_grant), 64'(e.g));
            check("a_mem_cycle", 64'(cyc), 64'(e.cy));
         end
      end
      a_prev = a_mrd | a_mwr;
   end

   always @(negedge clk) begin
      if (!rst_a && a_done != 2'b00) begin
         if (a_rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL a_done_unexpected: req_done=%b with nothing expected", a_done);
         end else begin
            rexp_t e;
            logic [1:0] ev;
            e = a_rq.pop_front();
            ev = 2'b01 << e.ch;
            check("a_done_vec", 64'(a_done), 64'(ev));
            check("a_err_vec", 64'(a_err), e.err ? 64'(ev) : 64'd0);
            check("a_readdata", a_rdata, e.data);
            check("a_busy_in_done", 64'(a_busy), 64'd1);
            if (e.cy >= 0) check("a_done_cycle", 64'(cyc), 64'(e.cy));
         end
      end
   end

   task automatic a_req(input int ch, input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [1:0] sz, input logic [63:0] wd);
      a_addr[ch*64 +: 64]  = addr;
      a_size[ch*2 +: 2]    = sz;
      a_wdata[ch*64 +: 64] = wd;
      a_rd[ch] = rd;
      a_wr[ch] = wr;
   endtask

   task automatic a_wait_done(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (a_done == 2'b00 && n < budget);
      if (a_done == 2'b00) begin
         n_chk++; n_fail++;
         $display("FAIL a_done_timeout: no req_done within %0d cycles", budget);
      end
   endtask

   // ---------------- instance B: N_CH=4, round robin, no watchdog
   logic          rst_b = 1'b1;
   logic [63:0]   b_addr;
   logic [7:0]    b_size = 8'hFF;
   logic [3:0]    b_rd = '0;
   logic [3:0]    b_wr = '0;
   logic [127:0]  b_wdata = '0;
   logic [31:0]   b_rdata;
   logic [3:0]    b_done, b_err;
   logic [1:0]    b_grant;
   logic          b_busy;
   logic [15:0]   b_maddr;
   logic [1:0]    b_msize;
   logic          b_mrd, b_mwr;
   logic [31:0]   b_mwdata;
   logic          b_mdone = 1'b0;
   logic          b_run = 1'b0;
   int            b_srv[4] = '{0, 0, 0, 0};
   int            b_quota[4] = '{2, 1, 1, 1};
   logic [3:0]    b_started = '0;
   int            b_total = 0;
   rexp_t         b_rq[$];

   assign b_addr = {16'h1030, 16'h1020, 16'h1010, 16'h1000};

   mmix_mem_arbiter #(.N_CH(4), .ADDR_W(16), .DATA_W(32), .MODE(1), .TIMEOUT(0)) u_b (
      .clk(clk), .reset(rst_b),
      .req_address(b_addr), .req_datasize(b_size), .req_read(b_rd), .req_write(b_wr),
      .req_writedata(b_wdata), .req_readdata(b_rdata), .req_done(b_done), .req_err(b_err),
      .grant(b_grant), .busy(b_busy),
      .mem_address(b_maddr), .mem_datasize(b_msize), .mem_read(b_mrd), .mem_write(b_mwr),
      .mem_writedata(b_mwdata), .mem_readdata({16'hB000, b_maddr}), .mem_done(b_mdone)
   );

   always @(negedge clk) b_mdone = b_mrd | b_mwr;

   // requesters drop on done and re-assert once another access is underway
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (b_done[i]) begin
            b_rd[i] = 1'b0;
            b_srv[i]++;
            b_total++;
         end else if (b_run && !b_rd[i] && b_srv[i] < b_quota[i] && (!b_started[i] || b_busy)) begin
            b_rd[i] = 1'b1;
            b_started[i] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_b && b_done != 4'b0000) begin
         if (b_rq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL b_done_unexpected: req_done=%b with nothing expected", b_done);
         end else begin
            rexp_t e;
            e = b_rq.pop_front();
            check("b_done_vec", 64'(b_done), 64'(4'b0001 << e.ch));
            check("b_err_vec", 64'(b_err), 64'd0);
            check("b_grant", 64'(b_grant), 64'(e.ch));
            check("b_readdata", 64'(b_rdata), e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   int t, r, n;
   int order[5] = '{0, 1, 2, 3, 0};

   initial begin
      repeat (2) @(negedge clk);
      check("rst_mem_read", 64'(a_mrd), 64'd0);
      check("rst_mem_write", 64'(a_mwr), 64'd0);
      check("rst_mem_address", a_maddr, 64'd0);
      check("rst_req_done", 64'(a_done), 64'd0);
      check("rst_readdata", a_rdata, 64'd0);
      check("rst_grant", 64'(a_grant), 64'd0);
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_b_grant", 64'(b_grant), 64'd0);
      rst_a = 1'b0;
      @(negedge clk);

      // single read on ch1, 2-cycle memory latency
      a_fix_en = 1'b1; a_fix = 64'hDEADBEEF_CAFEF00D; a_lat = 2; t = cyc;
      a_mq.push_back('{64'h100, 2'd3, 1'b0, 64'h0, 1, t + 1});
      a_rq.push_back('{1, 64'hDEADBEEF_CAFEF00D, 1'b0, t + 4});
      a_req(1, 1'b1, 1'b0, 64'h100, 2'd3, 64'h0);
      a_wait_done(20); a_rd[1] = 1'b0;
      @(negedge clk);

      // read+write together is a write; readdata keeps the previous read value
      a_fix = 64'h1111_2222_3333_4444; a_lat = 0; t = cyc;
      a_mq.push_back('{64'h200, 2'd0, 1'b1, 64'h55, 0, t + 1});
      a_rq.push_back('{0, 64'hDEADBEEF_CAFEF00D, 1'b0, t + 2});
      a_req(0, 1'b1, 1'b1, 64'h200, 2'd0, 64'h55);
      a_wait_done(20); a_rd[0] = 1'b0; a_wr[0] = 1'b0;
      @(negedge clk);

      // fixed priority: ch0 then ch1, ch1 granted two cycles after ch0's mem_done
      a_fix_en = 1'b0; a_lat = 1; t = cyc;
      a_mq.push_back('{64'h300, 2'd3, 1'b0, 64'h0, 0, t + 1});
      a_mq.push_back('{64'h400, 2'd1, 1'b0, 64'h0, 1, t + 5});
      a_rq.push_back('{0, ~64'h300, 1'b0, t + 3});
      a_rq.push_back('{1, ~64'h400, 1'b0, t + 7});
      a_req(0, 1'b1, 1'b0, 64'h300, 2'd3, 64'h0);
      a_req(1, 1'b1, 1'b0, 64'h400, 2'd1, 64'h0);
      a_wait_done(20); a_rd[0] = 1'b0;
      a_wait_done(20); a_rd[1] = 1'b0;
      @(negedge clk);

      // watchdog expiry with no mem_done
      a_lat = 1000; t = cyc;
      a_mq.push_back('{64'h500, 2'd2, 1'b0, 64'h0, 0, t + 1});
      a_rq.push_back('{0, 64'h0, 1'b1, t + 10});
      a_req(0, 1'b1, 1'b0, 64'h500, 2'd2, 64'h0);
      a_wait_done(30);
      check("wd_mem_read_in_done", 64'(a_mrd), 64'd0);
      a_rd[0] = 1'b0;
      @(negedge clk);

      // mem_done in the expiry cycle completes without error
      a_lat = 8; t = cyc;
      a_mq.push_back('{64'h600, 2'd3, 1'b0, 64'h0, 1, t + 1});
      a_rq.push_back('{1, ~64'h600, 1'b0, t + 10});
      a_req(1, 1'b1, 1'b0, 64'h600, 2'd3, 64'h0);
      a_wait_done(30); a_rd[1] = 1'b0;
      @(negedge clk);

      // reset during BUSY drops mem_read at once; held request is served after release
      a_lat = 1000; t = cyc;
      a_mq.push_back('{64'h700, 2'd3, 1'b0, 64'h0, 1, t + 1});
      a_req(1, 1'b1, 1'b0, 64'h700, 2'd3, 64'h0);
      repeat (3) @(negedge clk);
      rst_a = 1'b1; a_lat = 2;
      #1;
      check("rst_mid_mem_read", 64'(a_mrd), 64'd0);
      check("rst_mid_busy", 64'(a_busy), 64'd0);
      check("rst_mid_done", 64'(a_done), 64'd0);
      repeat (2) @(negedge clk);
      r = cyc;
      a_mq.push_back('{64'h700, 2'd3, 1'b0, 64'h0, 1, r + 1});
      a_rq.push_back('{1, ~64'h700, 1'b0, r + 4});
      rst_a = 1'b0;
      a_wait_done(20); a_rd[1] = 1'b0;
      @(negedge clk);
      check("a_mem_queue_drained", 64'(a_mq.size()), 64'd0);
      check("a_done_queue_drained", 64'(a_rq.size()), 64'd0);

      // round robin over four continuously requesting channels
      for (int i = 0; i < 5; i++)
         b_rq.push_back('{order[i], 64'({16'hB000, 16'h1000 + 16'(order[i] * 16)}), 1'b0, -1});
      rst_b = 1'b0;
      @(negedge clk);
      b_run = 1'b1;
      n = 0;
      while (b_total < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (b_total < 5) begin
         n_chk++; n_fail++;
         $display("FAIL b_rr_timeout: %0d of 5 accesses completed", b_total);
      end
      repeat (4) @(negedge clk);
      check("b_done_queue_drained", 64'(b_rq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
